vscale_alu_xvec_seq: RTL and testbench

Lane-serial vector ALU for the xvec extension, sitting directly downstream of the xvec source-operand muxes in the DX stage. It accepts a packed `VEC_LEN`-lane `alu_src_a`/`alu_src_b` pair and an ALU op, and evaluates one lane per cycle. It returns the packed result through a valid/ready handshake. It also drives `busy` so the pipeline control stalls DX while a vector op is in flight.

---
 rtl/vscale_alu_xvec_seq.sv | 109 ++++++++++
 tb/tb_vscale_alu_xvec_seq.sv | 130 +++++++++++++
 2 files changed

// File: rtl/vscale_alu_xvec_seq.sv
// vscale_alu_xvec_seq: lane-serial xvec vector ALU, one lane per cycle, valid/ready response.
module vscale_alu_xvec_seq #(
  parameter int VEC_LEN      = 4,
  parameter int XPR_LEN      = 32,
  parameter int ALU_OP_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ALU_OP_WIDTH-1:0]     req_op,
  input  logic                        req_scalar_b,
  input  logic [VEC_LEN*XPR_LEN-1:0]  alu_src_a,
  input  logic [VEC_LEN*XPR_LEN-1:0]  alu_src_b,
  input  logic                        kill,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [VEC_LEN*XPR_LEN-1:0]  resp_data,
  output logic                        busy
);
  localparam int W  = VEC_LEN * XPR_LEN;
  localparam int CW = VEC_LEN > 1 ? $clog2(VEC_LEN) : 1;
  localparam logic [ALU_OP_WIDTH-1:0] OP_ADD  = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLL  = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] OP_XOR  = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SRL  = ALU_OP_WIDTH'(5);
  localparam logic [ALU_OP_WIDTH-1:0] OP_OR   = ALU_OP_WIDTH'(6);
  localparam logic [ALU_OP_WIDTH-1:0] OP_AND  = ALU_OP_WIDTH'(7);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SEQ  = ALU_OP_WIDTH'(8);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SNE  = ALU_OP_WIDTH'(9);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SUB  = ALU_OP_WIDTH'(10);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SRA  = ALU_OP_WIDTH'(11);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLT  = ALU_OP_WIDTH'(12);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SGE  = ALU_OP_WIDTH'(13);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLTU = ALU_OP_WIDTH'(14);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SGEU = ALU_OP_WIDTH'(15);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_next;
  logic [W-1:0] a_q, b_q;
  logic [ALU_OP_WIDTH-1:0] op_q;
  logic [CW-1:0] lane_cnt;
  logic [XPR_LEN-1:0] a_lane, b_lane, res;
  logic [4:0] shamt;
  logic last, lt, ltu, eq;
  assign a_lane = a_q[lane_cnt*XPR_LEN +: XPR_LEN];
  assign b_lane = b_q[lane_cnt*XPR_LEN +: XPR_LEN];
  assign shamt  = b_lane[4:0];
  assign last   = lane_cnt == CW'(VEC_LEN - 1);
  assign lt     = $signed(a_lane) < $signed(b_lane);
  assign ltu    = a_lane < b_lane;
  assign eq     = a_lane == b_lane;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = req_valid ? BUSY : IDLE;
      BUSY:    state_next = kill ? IDLE : last ? DONE : BUSY;
      DONE:    state_next = (kill || resp_ready) ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end
  always_comb begin
    req_ready  = state == IDLE;
    resp_valid = state == DONE;
    busy       = state != IDLE;
  end
  always_comb begin
    res = '0;
    case (op_q)
      OP_ADD:  res = a_lane + b_lane;
      OP_SUB:  res = a_lane - b_lane;
      OP_XOR:  res = a_lane ^ b_lane;
      OP_OR:   res = a_lane | b_lane;
      OP_AND:  res = a_lane & b_lane;
      OP_SLL:  res = a_lane << shamt;
      OP_SRL:  res = a_lane >> shamt;
      OP_SRA:  res = $signed(a_lane) >>> shamt;
      OP_SEQ:  res = {{(XPR_LEN-1){1'b0}}, eq};
      OP_SNE:  res = {{(XPR_LEN-1){1'b0}}, !eq};
      OP_SLT:  res = {{(XPR_LEN-1){1'b0}}, lt};
      OP_SGE:  res = {{(XPR_LEN-1){1'b0}}, !lt};
      OP_SLTU: res = {{(XPR_LEN-1){1'b0}}, ltu};
      OP_SGEU: res = {{(XPR_LEN-1){1'b0}}, !ltu};
      default: res = '0;
    endcase
  end
  // scalar B is expanded at accept time so the lane loop never needs to know about it
  always_ff @(posedge clk)
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      lane_cnt  <= '0;
      resp_data <= '0;
    end else if (state == IDLE && req_valid) begin
      a_q       <= alu_src_a;
      b_q       <= req_scalar_b ? {VEC_LEN{alu_src_b[XPR_LEN-1:0]}} : alu_src_b;
      op_q      <= req_op;
      lane_cnt  <= '0;
      resp_data <= '0;
    end else if (state == BUSY && kill) begin
      lane_cnt <= '0;
    end else if (state == BUSY) begin
      resp_data[lane_cnt*XPR_LEN +: XPR_LEN] <= res;
      lane_cnt <= last ? '0 : lane_cnt + 1'b1;
    end
endmodule

// File: tb/tb_vscale_alu_xvec_seq.sv
// tb_vscale_alu_xvec_seq: vector table plus scoreboard for the lane-serial xvec ALU.
module tb_vscale_alu_xvec_seq;
  localparam int VL = 4;
  localparam int W  = VL * 32;
  typedef struct {
    logic [3:0]   op;
    logic         sc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;
  logic clk = 0, reset, req_valid, req_ready, req_scalar_b, kill, resp_valid, resp_ready, busy;
  logic [3:0] req_op;
  logic [W-1:0] alu_src_a, alu_src_b, resp_data;
  logic [W-1:0] sb[$];
  vec_t tbl[15];
  int n_pass = 0, n_chk = 0;
  vscale_alu_xvec_seq #(.VEC_LEN(VL), .XPR_LEN(32), .ALU_OP_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_scalar_b(req_scalar_b), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .kill(kill),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  function automatic void check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endfunction
  always @(negedge clk)
    if (!reset && resp_valid && resp_ready) begin
      if (sb.size() == 0) check("unexpected_resp", W'(resp_valid), '0);
      else check("resp_data", resp_data, sb.pop_front());
    end
  task automatic issue(input vec_t v, input bit push);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", W'(req_ready), W'(1));
    req_valid = 1; req_op = v.op; req_scalar_b = v.sc; alu_src_a = v.a; alu_src_b = v.b;
    @(posedge clk);
    if (push) sb.push_back(v.exp);
    #1 req_valid = 0;
  endtask
  task automatic run(input vec_t v);
    issue(v, 1);
    for (int k = 1; k <= VL; k++) begin
      @(negedge clk);
      check($sformatf("busy_phase_c%0d", k), W'({busy, resp_valid, req_ready}), W'(3'b100));
    end
    @(negedge clk);
    check("done_phase", W'({busy, resp_valid, req_ready}), W'(3'b110));
  endtask
  initial begin
    tbl[0]  = '{4'd0,  1'b0, {32'hFFFFFFFF, 32'd3, 32'd2, 32'd1}, {32'd1, 32'd30, 32'd20, 32'd10}, {32'd0, 32'd33, 32'd22, 32'd11}};
    tbl[1]  = '{4'd11, 1'b1, {32'h7FFFFFFF, 32'hF0, 32'h10, 32'h80000000}, {32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h24}, {32'h07FFFFFF, 32'hF, 32'h1, 32'hF8000000}};
    tbl[2]  = '{4'd12, 1'b0, {32'h80000000, 32'd1, 32'd5, 32'hFFFFFFFF}, {32'h7FFFFFFF, 32'd2, 32'd5, 32'd1}, {32'd1, 32'd1, 32'd0, 32'd1}};
    tbl[3]  = '{4'd14, 1'b0, {32'h80000000, 32'd1, 32'd5, 32'hFFFFFFFF}, {32'h7FFFFFFF, 32'd2, 32'd5, 32'd1}, {32'd0, 32'd1, 32'd0, 32'd0}};
    tbl[4]  = '{4'd10, 1'b0, {32'hFFFFFFFF, 32'h80000000, 32'd10, 32'd0}, {32'hFFFFFFFF, 32'd1, 32'd3, 32'd1}, {32'd0, 32'h7FFFFFFF, 32'd7, 32'hFFFFFFFF}};
    tbl[5]  = '{4'd4,  1'b0, {32'h12345678, 32'hFFFF0000, 32'd0, 32'hAAAAAAAA}, {32'h0F0F0F0F, 32'h00FF00FF, 32'hFFFFFFFF, 32'h55555555}, {32'h1D3B5977, 32'hFF0000FF, 32'hFFFFFFFF, 32'hFFFFFFFF}};
    tbl[6]  = '{4'd7,  1'b0, {32'h12345678, 32'hFFFF0000, 32'd0, 32'hAAAAAAAA}, {32'h0F0F0F0F, 32'h00FF00FF, 32'hFFFFFFFF, 32'h55555555}, {32'h02040608, 32'h00FF0000, 32'd0, 32'd0}};
    tbl[7]  = '{4'd6,  1'b0, {32'h12345678, 32'hFFFF0000, 32'd0, 32'hAAAAAAAA}, {32'h0F0F0F0F, 32'h00FF00FF, 32'hFFFFFFFF, 32'h55555555}, {32'h1F3F5F7F, 32'hFFFF00FF, 32'hFFFFFFFF, 32'hFFFFFFFF}};
    tbl[8]  = '{4'd1,  1'b0, {32'd1, 32'd1, 32'h80000001, 32'h0000FFFF}, {32'h1F, 32'h20, 32'd1, 32'd4}, {32'h80000000, 32'd1, 32'd2, 32'h000FFFF0}};
    tbl[9]  = '{4'd5,  1'b0, {32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'h12345678}, {32'h1F, 32'd1, 32'd4, 32'd8}, {32'd1, 32'h40000000, 32'h0FFFFFFF, 32'h00123456}};
    tbl[10] = '{4'd8,  1'b0, {32'd5, 32'd5, 32'd0, 32'hFFFFFFFF}, {32'd5, 32'd6, 32'd0, 32'hFFFFFFFE}, {32'd1, 32'd0, 32'd1, 32'd0}};
    tbl[11] = '{4'd9,  1'b0, {32'd5, 32'd5, 32'd0, 32'hFFFFFFFF}, {32'd5, 32'd6, 32'd0, 32'hFFFFFFFE}, {32'd0, 32'd1, 32'd0, 32'd1}};
    tbl[12] = '{4'd13, 1'b0, {32'hFFFFFFFF, 32'd1, 32'h80000000, 32'd5}, {32'd0, 32'd1, 32'h7FFFFFFF, 32'd3}, {32'd0, 32'd1, 32'd0, 32'd1}};
    tbl[13] = '{4'd15, 1'b0, {32'hFFFFFFFF, 32'd1, 32'h80000000, 32'd5}, {32'd0, 32'd1, 32'h7FFFFFFF, 32'd3}, {32'd1, 32'd1, 32'd1, 32'd1}};
    tbl[14] = '{4'd2,  1'b0, {32'h12345678, 32'd1, 32'd2, 32'd3}, {32'd4, 32'd5, 32'd6, 32'd7}, {32'd0, 32'd0, 32'd0, 32'd0}};
    reset = 1; req_valid = 1; req_op = '0; req_scalar_b = 0; alu_src_a = '1; alu_src_b = '1;
    kill = 0; resp_ready = 1;
    repeat (3) @(posedge clk);
    #1 check("busy_in_reset", W'(busy), '0);
    reset = 0; req_valid = 0;
    @(negedge clk);
    check("post_reset_flags", W'({busy, resp_valid, req_ready}), W'(3'b001));
    check("post_reset_data", resp_data, '0);
    for (int i = 0; i < 15; i++) begin
      run(tbl[i]);
      @(posedge clk);
      #1 check($sformatf("vec%0d_drained", i), W'(sb.size()), '0);
    end
    resp_ready = 0;
    run(tbl[1]);
    for (int h = 0; h < 10; h++) begin
      @(negedge clk);
      check("hold_flags", W'({resp_valid, req_ready}), W'(2'b10));
      check("hold_data", resp_data, tbl[1].exp);
      if (h == 3) begin req_valid = 1; req_op = 4'd0; end
      if (h == 4) req_valid = 0;
    end
    @(posedge clk);
    #1 resp_ready = 1;
    @(posedge clk);
    #1 check("hold_release_flags", W'({busy, resp_valid, req_ready}), W'(3'b001));
    check("hold_release_sb", W'(sb.size()), '0);
    issue(tbl[5], 0);
    @(posedge clk);
    #1 kill = 1;
    @(posedge clk);
    #1 kill = 0;
    check("kill_idle", W'({busy, resp_valid, req_ready}), W'(3'b001));
    run(tbl[0]);
    @(posedge clk);
    #1 check("kill_followup_sb", W'(sb.size()), '0);
    issue(tbl[6], 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 check("midop_reset_flags", W'({busy, resp_valid, req_ready}), W'(3'b001));
    check("midop_reset_data", resp_data, '0);
    reset = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k % 3 == 0) check("midop_no_resp", W'({busy, resp_valid}), '0);
    end
    check("final_sb_empty", W'(sb.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
